exception_sequencer: RTL and testbench

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

---
 rtl/exception_sequencer_pkg.sv | 42 ++++
 rtl/exception_sequencer_int_detect.sv | 17 +
 rtl/exception_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_exception_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_sequencer_pkg.sv
// Shared CP0 definitions: register indices, exception codes, the default
// exception entry vector and the sequencer state encoding.
package cp0_defs;

    // CP0 register indices written by the sequencer
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values carried in Cause[6:2]
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // General exception entry address
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    // Status bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    // Sequencer states; each lasts exactly one cycle except IDLE
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_EPC    = 3'd1,
        S_W_BADV   = 3'd2,
        S_W_CAUSE  = 3'd3,
        S_W_STATUS = 3'd4,
        S_E_STATUS = 3'd5,
        S_REDIRECT = 3'd6
    } seq_state_t;

endpackage

// File: rtl/exception_sequencer_int_detect.sv
// Interrupt pending detection: an enabled, unmasked interrupt line while
// not already at exception level. Purely combinational.
module int_detect (
    input  logic       ie,
    input  logic       exl,
    input  logic [7:0] im,
    input  logic [5:0] hw_int,
    input  logic [1:0] sw_int,
    output logic       int_pending
);

    // Hardware lines occupy IP[7:2], software lines IP[1:0]
    always_comb begin
        int_pending = ie & ~exl & (|(im & {hw_int, sw_int}));
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception / interrupt / ERET sequencer. Accepts one event from the commit
// stage, performs the CP0 writes one per cycle, then flushes and redirects
// fetch.
//
// Handshake: the sequencer samples mem_valid together with exc_req,
// int_pending or eret_req only while busy=0; an event is taken on the clock
// edge where it is seen in IDLE, and busy is high from the next cycle until
// the cycle after REDIRECT. While busy=1 all requests are ignored and the
// pipeline must keep holding them.
module exception_sequencer
    import cp0_defs::*;
#(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_bd,
    input  logic             exc_req,
    input  logic [4:0]       exc_code,
    input  logic             exc_badv_valid,
    input  logic [WIDTH-1:0] exc_badvaddr,
    input  logic             eret_req,
    input  logic [5:0]       hw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic             busy,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [WIDTH-1:0] cp0_wdata,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output seq_state_t       dbg_state
);

    seq_state_t       state;
    seq_state_t       nxt;
    logic             int_pending;

    // Event context captured at acceptance
    logic [WIDTH-1:0] pc_q;
    logic             bd_q;
    logic [4:0]       code_q;
    logic             badv_flag_q;
    logic [WIDTH-1:0] badvaddr_q;
    logic             exl_q;

    // Context seen by the next-state logic: live inputs in the accepting
    // cycle, the captured copy afterwards
    logic [WIDTH-1:0] src_pc;
    logic             src_bd;
    logic [4:0]       src_code;
    logic             src_badv_flag;
    logic [WIDTH-1:0] src_badvaddr;
    logic             src_exl;

    logic             nxt_we;
    logic [4:0]       nxt_waddr;
    logic [WIDTH-1:0] nxt_wdata;
    logic             nxt_redirect;
    logic [WIDTH-1:0] nxt_rpc;
    logic             cause_bd;
    logic [31:0]      cause_word;

    // Cause bits that the sequencer neither reads nor rewrites from the input
    logic unused_cause_bits;
    assign unused_cause_bits = ^{cause_in[15:10], cause_in[7:0]};

    assign dbg_state = state;

    int_detect u_int_detect (
        .ie          (status_in[STATUS_IE]),
        .exl         (status_in[STATUS_EXL]),
        .im          (status_in[15:8]),
        .hw_int      (hw_int),
        .sw_int      (cause_in[9:8]),
        .int_pending (int_pending)
    );

    // Select live or captured event context
    always_comb begin
        if (state == S_IDLE) begin
            src_pc        = mem_pc;
            src_bd        = mem_bd;
            src_code      = exc_req ? exc_code : EXC_INT;
            src_badv_flag = exc_req & exc_badv_valid;
            src_badvaddr  = exc_badvaddr;
            src_exl       = status_in[STATUS_EXL];
        end else begin
            src_pc        = pc_q;
            src_bd        = bd_q;
            src_code      = code_q;
            src_badv_flag = badv_flag_q;
            src_badvaddr  = badvaddr_q;
            src_exl       = exl_q;
        end
    end

    // Next state and the CP0 write / redirect values belonging to it
    always_comb begin
        nxt          = S_IDLE;
        nxt_we       = 1'b0;
        nxt_waddr    = 5'd0;
        nxt_wdata    = '0;
        nxt_redirect = 1'b0;
        nxt_rpc      = '0;
        // Nested exceptions keep the original EPC, so BD must stay as well
        cause_bd     = src_exl ? cause_in[31] : src_bd;
        cause_word   = {cause_bd, cause_in[30:16], hw_int, cause_in[9:8],
                        1'b0, src_code, 2'b00};

        case (state)
            S_IDLE: begin
                if (mem_valid && (exc_req || int_pending)) begin
                    if (!src_exl)           nxt = S_W_EPC;
                    else if (src_badv_flag) nxt = S_W_BADV;
                    else                    nxt = S_W_CAUSE;
                end else if (mem_valid && eret_req) begin
                    nxt = S_E_STATUS;
                end
            end
            S_W_EPC:    nxt = src_badv_flag ? S_W_BADV : S_W_CAUSE;
            S_W_BADV:   nxt = S_W_CAUSE;
            S_W_CAUSE:  nxt = S_W_STATUS;
            S_W_STATUS: nxt = S_REDIRECT;
            S_E_STATUS: nxt = S_REDIRECT;
            default:    nxt = S_IDLE;
        endcase

        case (nxt)
            S_W_EPC: begin
                nxt_we    = 1'b1;
                nxt_waddr = CP0_EPC;
                nxt_wdata = src_bd ? (src_pc - WIDTH'(4)) : src_pc;
            end
            S_W_BADV: begin
                nxt_we    = 1'b1;
                nxt_waddr = CP0_BADVADDR;
                nxt_wdata = src_badvaddr;
            end
            S_W_CAUSE: begin
                nxt_we    = 1'b1;
                nxt_waddr = CP0_CAUSE;
                nxt_wdata = WIDTH'(cause_word);
            end
            S_W_STATUS: begin
                nxt_we    = 1'b1;
                nxt_waddr = CP0_STATUS;
                nxt_wdata = status_in | WIDTH'(2);
            end
            S_E_STATUS: begin
                nxt_we    = 1'b1;
                nxt_waddr = CP0_STATUS;
                nxt_wdata = status_in & ~WIDTH'(2);
            end
            S_REDIRECT: begin
                nxt_redirect = 1'b1;
                nxt_rpc      = (state == S_E_STATUS) ? epc_in : EXC_VECTOR;
            end
            default: ;
        endcase
    end

    // Sequencer state, registered outputs and captured event context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            cp0_we         <= 1'b0;
            cp0_waddr      <= 5'd0;
            cp0_wdata      <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            pc_q           <= '0;
            bd_q           <= 1'b0;
            code_q         <= 5'd0;
            badv_flag_q    <= 1'b0;
            badvaddr_q     <= '0;
            exl_q          <= 1'b0;
        end else begin
            state          <= nxt;
            busy           <= (nxt != S_IDLE);
            cp0_we         <= nxt_we;
            cp0_waddr      <= nxt_waddr;
            cp0_wdata      <= nxt_wdata;
            flush          <= nxt_redirect;
            redirect_valid <= nxt_redirect;
            redirect_pc    <= nxt_rpc;
            if (state == S_IDLE) begin
                pc_q        <= src_pc;
                bd_q        <= src_bd;
                code_q      <= src_code;
                badv_flag_q <= src_badv_flag;
                badvaddr_q  <= src_badvaddr;
                exl_q       <= src_exl;
            end
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: directed scenarios plus
// randomized events compared cycle by cycle against a reference model.
module tb_exception_sequencer;
    import cp0_defs::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_badv_valid;
    logic [31:0] exc_badvaddr;
    logic        eret_req;
    logic [5:0]  hw_int;
    logic [31:0] status_in;
    logic [31:0] cause_in;
    logic [31:0] epc_in;
    logic        busy;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    seq_state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    // One expected cycle: {busy, we, waddr, wdata, flush, redirect_valid, redirect_pc}
    logic [72:0] exp_q[$];

    exception_sequencer #(.WIDTH(32), .EXC_VECTOR(VEC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .exc_badv_valid (exc_badv_valid),
        .exc_badvaddr   (exc_badvaddr),
        .eret_req       (eret_req),
        .hw_int         (hw_int),
        .status_in      (status_in),
        .cause_in       (cause_in),
        .epc_in         (epc_in),
        .busy           (busy),
        .cp0_we         (cp0_we),
        .cp0_waddr      (cp0_waddr),
        .cp0_wdata      (cp0_wdata),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state      (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [72:0] entry(input logic b, input logic we, input logic [4:0] a,
                                          input logic [31:0] d, input logic rd,
                                          input logic [31:0] rpc);
        return {b, we, a, d, rd, rd, rpc};
    endfunction

    function automatic logic [72:0] observed();
        return {busy, cp0_we, cp0_waddr, cp0_wdata, flush, redirect_valid, redirect_pc};
    endfunction

    // Driver tasks
    task automatic drive_quiet();
        mem_valid = 0; mem_pc = 0; mem_bd = 0; exc_req = 0; exc_code = 0;
        exc_badv_valid = 0; exc_badvaddr = 0; eret_req = 0; hw_int = 0;
        status_in = 0; cause_in = 0; epc_in = 0;
    endtask

    task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                             input logic bv, input logic [31:0] bva);
        mem_valid = 1; exc_req = 1; exc_code = code; mem_pc = pc; mem_bd = bd;
        exc_badv_valid = bv; exc_badvaddr = bva;
    endtask

    // Reference model: list of CP0 writes and the redirect for the event
    // currently presented on the inputs, then one quiet idle cycle.
    task automatic model_build();
        logic        pend;
        logic [31:0] cause_w;
        logic        bdbit;
        logic [4:0]  code;
        exp_q.delete();
        pend = status_in[0] && !status_in[1] &&
               ((status_in[15:8] & {hw_int, cause_in[9:8]}) != 8'd0);
        if (mem_valid && (exc_req || pend)) begin
            code = exc_req ? exc_code : 5'd0;
            if (!status_in[1])
                exp_q.push_back(entry(1, 1, 5'd14, mem_bd ? mem_pc - 32'd4 : mem_pc, 0, 0));
            if (exc_req && exc_badv_valid)
                exp_q.push_back(entry(1, 1, 5'd8, exc_badvaddr, 0, 0));
            bdbit = status_in[1] ? cause_in[31] : mem_bd;
            cause_w = (cause_in & 32'h7FFF_0300) + (32'(bdbit) << 31)
                    + (32'(hw_int) << 10) + (32'(code) << 2);
            exp_q.push_back(entry(1, 1, 5'd13, cause_w, 0, 0));
            exp_q.push_back(entry(1, 1, 5'd12, status_in | 32'd2, 0, 0));
            exp_q.push_back(entry(1, 0, 5'd0, 32'd0, 1, VEC));
        end else if (mem_valid && eret_req) begin
            exp_q.push_back(entry(1, 1, 5'd12, status_in & ~32'd2, 0, 0));
            exp_q.push_back(entry(1, 0, 5'd0, 32'd0, 1, epc_in));
        end
        exp_q.push_back(entry(0, 0, 5'd0, 32'd0, 0, 0));
    endtask

    // Scoreboard: compare each cycle after acceptance against the model.
    // Strobes stay asserted for 'hold' cycles; 'alt' swaps in a second,
    // different exception while the first is still being sequenced.
    task automatic check_seq(input string name, input int redir_cycle, input int hold,
                             input bit alt);
        int          n;
        int          seen;
        logic [72:0] e;
        logic [72:0] o;
        n = exp_q.size();
        seen = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, o, e);
            end
            if (flush === 1'b1 && seen == 0) seen = i;
            if (alt && i == 1) begin
                exc_req = 1; exc_code = EXC_OV; mem_pc = 32'h1234_5678; eret_req = 0;
            end
            if (i >= hold) begin
                mem_valid = 0; exc_req = 0; eret_req = 0;
            end
        end
        if (redir_cycle > 0) begin
            checks++;
            if (seen !== redir_cycle) begin
                errors++;
                $display("FAIL %s redirect cycle: got %0d expected %0d", name, seen, redir_cycle);
            end
        end
    endtask

    task automatic test_reset();
        drive_quiet();
        rst = 1;
        status_in = 32'h0000_FF00;
        drive_exc(EXC_ADEL, 32'h8000_1000, 0, 1, 32'h3);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (observed() !== 73'd0 || dbg_state !== S_IDLE) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 0", observed());
            end
        end
        model_build();
        rst = 0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
        check_seq("first_after_reset", 5, 0, 0);
    endtask

    task automatic test_adel();
        drive_quiet();
        status_in = 32'h0000_FF00;
        drive_exc(EXC_ADEL, 32'h8000_1000, 0, 1, 32'h0000_0003);
        model_build();
        check_seq("adel", 5, 0, 0);
    endtask

    task automatic test_syscall_bd();
        drive_quiet();
        status_in = 32'h0000_FF00;
        drive_exc(EXC_SYS, 32'h8000_2004, 1, 0, 32'hDEAD_BEEF);
        model_build();
        check_seq("syscall_bd", 4, 0, 0);
    endtask

    task automatic test_interrupt();
        drive_quiet();
        status_in = 32'h0000_FF01;
        hw_int = 6'b100000;
        mem_valid = 1;
        mem_pc = 32'h8000_4000;
        model_build();
        check_seq("interrupt", 4, 0, 0);
    endtask

    task automatic test_eret();
        drive_quiet();
        status_in = 32'h0000_FF03;
        epc_in = 32'h8000_3000;
        mem_valid = 1;
        eret_req = 1;
        model_build();
        check_seq("eret", 2, 0, 0);
    endtask

    task automatic test_exc_eret_simul();
        drive_quiet();
        status_in = 32'h0000_0000;
        epc_in = 32'h8000_3000;
        drive_exc(EXC_RI, 32'h8000_5000, 0, 0, 32'h0);
        eret_req = 1;
        model_build();
        check_seq("exc_eret_simul", 4, 0, 0);
    endtask

    task automatic test_busy_ignored();
        drive_quiet();
        status_in = 32'h0000_FF00;
        drive_exc(EXC_ADEL, 32'h8000_6000, 0, 1, 32'h0000_0101);
        model_build();
        check_seq("busy_ignored", 5, 3, 1);
    endtask

    task automatic test_exl_nested();
        drive_quiet();
        status_in = 32'h0000_0003;
        cause_in = 32'h8000_0000;
        drive_exc(EXC_RI, 32'h8000_7000, 0, 0, 32'h0);
        model_build();
        check_seq("exl_nested", 3, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive_quiet();
        status_in = 32'h0000_FF00;
        drive_exc(EXC_ADEL, 32'h8000_1000, 0, 1, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mem_valid = 0; exc_req = 0;
        end
        checks++;
        if (cp0_waddr !== 5'd13 || dbg_state !== S_W_CAUSE) begin
            errors++;
            $display("FAIL reset_mid_precond: got waddr=%0d state=%0d expected 13/%0d",
                     cp0_waddr, dbg_state, S_W_CAUSE);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (observed() !== 73'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_mid_async: got %h state=%0d expected 0", observed(), dbg_state);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cp0_we !== 1'b0 || busy !== 1'b0 || flush !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: got we=%b busy=%b flush=%b expected 0",
                         cp0_we, busy, flush);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            drive_quiet();
            mem_valid      = ($urandom_range(0, 7) != 0);
            mem_pc         = $urandom;
            mem_bd         = 1'($urandom_range(0, 1));
            exc_req        = ($urandom_range(0, 2) == 0);
            exc_code       = 5'($urandom_range(0, 31));
            exc_badv_valid = 1'($urandom_range(0, 1));
            exc_badvaddr   = $urandom;
            eret_req       = ($urandom_range(0, 2) == 0);
            hw_int         = 6'($urandom_range(0, 63));
            status_in      = $urandom;
            cause_in       = $urandom;
            epc_in         = $urandom;
            model_build();
            check_seq("random", 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1;
        drive_quiet();
        test_reset();
        test_adel();
        test_syscall_bd();
        test_interrupt();
        test_eret();
        test_exc_eret_simul();
        test_busy_ignored();
        test_exl_nested();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
